div_requester: RTL and testbench



---
 rtl/div_requester.sv | 138 +++++++++++++
 tb/tb_div_requester.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_requester.sv
// Queues operand pairs, issues them one at a time to the sequential divider,
// and returns quotient plus status; aborts a hung divider after TIMEOUT cycles.
module div_requester #(
  parameter int unsigned DW        = 10,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned START_CYC = 2,
  parameter int unsigned TIMEOUT   = 63
) (
  input  logic          clk,
  input  logic          sclr_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  output logic          div_start,
  output logic [DW-1:0] div_a,
  output logic [DW-1:0] div_b,
  output logic          div_sclr,
  input  logic          div_busy,
  input  logic          div_valid,
  input  logic          div_dvz,
  input  logic          div_ovf,
  input  logic [DW-1:0] div_q,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_q,
  output logic [1:0]    res_status,
  output logic          stray_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [SW-1:0] ST_LOAD  = SW'(START_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_REPORT} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] st_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_sclr;
  logic          push, pop, done_any, tmo_hit;
  logic          unused_busy;

  assign unused_busy = div_busy;

  assign cmd_ready = sclr_n && (count != FULL);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign done_any  = div_valid | div_dvz | div_ovf;
  // A completion pulse in the last WAIT cycle beats the timeout.
  assign tmo_hit   = (state == S_WAIT) && !done_any && (tmo_cnt == TMO_LAST);

  assign div_start = (state == S_START);
  assign res_valid = (state == S_REPORT);
  assign div_sclr  = !sclr_n || tmo_sclr;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (pop) state_nxt = S_START;
      S_START:  if (st_cnt == '0) state_nxt = S_WAIT;
      S_WAIT:   if (done_any || tmo_hit) state_nxt = S_REPORT;
      S_REPORT: if (res_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= cmd_a;
      mem_b[wr_ptr] <= cmd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      st_cnt     <= '0;
      tmo_cnt    <= '0;
      tmo_sclr   <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      res_q      <= '0;
      res_status <= '0;
      stray_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      tmo_sclr <= tmo_hit;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        div_a  <= mem_a[rd_ptr];
        div_b  <= mem_b[rd_ptr];
        st_cnt <= ST_LOAD;
      end else if (state == S_START && st_cnt != '0) begin
        st_cnt <= st_cnt - 1'b1;
      end

      if (state == S_START) tmo_cnt <= '0;
      else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 1'b1;

      if (state == S_WAIT) begin
        if (div_dvz) begin
          res_q      <= '0;
          res_status <= 2'b01;
        end else if (div_ovf) begin
          res_q      <= '0;
          res_status <= 2'b10;
        end else if (div_valid) begin
          res_q      <= div_q;
          res_status <= 2'b00;
        end else if (tmo_hit) begin
          res_q      <= '0;
          res_status <= 2'b11;
        end
      end else if (done_any) begin
        stray_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_requester.sv
module tb_div_requester;

  localparam int unsigned DW = 10;

  logic          clk = 1'b0;
  logic          sclr_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a, cmd_b;
  logic          div_start;
  logic [DW-1:0] div_a, div_b;
  logic          div_sclr;
  logic          div_busy;
  logic          div_valid, div_dvz, div_ovf;
  logic [DW-1:0] div_q;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_q;
  logic [1:0]    res_status;
  logic          stray_err;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [DW-1:0] ja [6];
  logic [DW-1:0] jb [6];
  logic [DW-1:0] jq [6];

  div_requester #(.DW(10), .DEPTH(4), .START_CYC(2), .TIMEOUT(63)) dut (
    .clk(clk), .sclr_n(sclr_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_sclr(div_sclr),
    .div_busy(div_busy), .div_valid(div_valid), .div_dvz(div_dvz), .div_ovf(div_ovf),
    .div_q(div_q),
    .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q), .res_status(res_status),
    .stray_err(stray_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_job(input logic [DW-1:0] a, input logic [DW-1:0] b);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Returns in the first WAIT cycle; lat = cycles until div_start, hi = its width.
  task automatic await_wait(output int unsigned lat, output int unsigned hi);
    lat = 0;
    hi  = 0;
    while (!div_start && lat < 20) begin
      tick();
      lat++;
    end
    while (div_start && hi < 20) begin
      tick();
      hi++;
    end
  endtask

  task automatic pulse(input logic v, input logic d, input logic o, input logic [DW-1:0] q);
    div_valid = v;
    div_dvz   = d;
    div_ovf   = o;
    div_q     = q;
    tick();
    div_valid = 1'b0;
    div_dvz   = 1'b0;
    div_ovf   = 1'b0;
    div_q     = '0;
  endtask

  task automatic take_result(input string tag, input logic [DW-1:0] q, input logic [1:0] st);
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_q"}, 32'(res_q), 32'(q));
    chk({tag, "_status"}, 32'(res_status), 32'(st));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_released"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    int unsigned lat, hi, cnt_a, cnt_b;

    for (int i = 0; i < 6; i++) begin
      ja[i] = DW'(60 + 13 * i);
      jb[i] = DW'(i + 2);
      jq[i] = ja[i] / jb[i];
    end

    sclr_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0;
    div_busy = 1'b0; div_valid = 1'b0; div_dvz = 1'b0; div_ovf = 1'b0; div_q = '0;
    res_ready = 1'b0;

    // Reset
    #1;
    chk("rst_sclr_pre", 32'(div_sclr), 32'd1);
    chk("rst_ready_pre", 32'(cmd_ready), 32'd0);
    tick();
    tick();
    chk("rst_start", 32'(div_start), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_stray", 32'(stray_err), 32'd0);
    chk("rst_res_q", 32'(res_q), 32'd0);
    chk("rst_status", 32'(res_status), 32'd0);
    chk("rst_div_a", 32'(div_a), 32'd0);
    chk("rst_div_b", 32'(div_b), 32'd0);
    chk("rst_sclr", 32'(div_sclr), 32'd1);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    sclr_n = 1'b1;
    tick();
    chk("rel_sclr", 32'(div_sclr), 32'd0);
    chk("rel_ready", 32'(cmd_ready), 32'd1);

    // Single ok job: 100 / 7 = 14
    push_job(10'd100, 10'd7);
    chk("ok_no_start_yet", 32'(div_start), 32'd0);
    await_wait(lat, hi);
    chk("ok_start_lat", lat, 32'd1);
    chk("ok_start_len", hi, 32'd2);
    repeat (19) tick();
    chk("ok_hold_a", 32'(div_a), 32'd100);
    chk("ok_hold_b", 32'(div_b), 32'd7);
    chk("ok_no_early_res", 32'(res_valid), 32'd0);
    pulse(1'b1, 1'b0, 1'b0, 10'd14);
    take_result("ok", 10'd14, 2'b00);

    // Divide by zero
    push_job(10'd5, 10'd0);
    await_wait(lat, hi);
    chk("dvz_start_len", hi, 32'd2);
    chk("dvz_div_b", 32'(div_b), 32'd0);
    repeat (3) tick();
    pulse(1'b0, 1'b1, 1'b0, 10'd9);
    take_result("dvz", 10'd0, 2'b01);

    // Backpressure and ordering
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_a = ja[i];
      cmd_b = jb[i];
      chk($sformatf("bp_ready%0d", i), 32'(cmd_ready), 32'd1);
      tick();
    end
    cmd_a = ja[5];
    cmd_b = jb[5];
    chk("bp_full", 32'(cmd_ready), 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("bp_a0", 32'(div_a), 32'(ja[0]));
    chk("bp_b0", 32'(div_b), 32'(jb[0]));
    pulse(1'b1, 1'b0, 1'b0, jq[0]);
    repeat (3) tick();
    chk("bp_hold_valid", 32'(res_valid), 32'd1);
    chk("bp_still_full", 32'(cmd_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      take_result($sformatf("bp_res%0d", k), jq[k], 2'b00);
      if (k < 4) begin
        await_wait(lat, hi);
        chk($sformatf("bp_start_len%0d", k + 1), hi, 32'd2);
        chk($sformatf("bp_a%0d", k + 1), 32'(div_a), 32'(ja[k + 1]));
        pulse(1'b1, 1'b0, 1'b0, jq[k + 1]);
      end
    end
    repeat (3) tick();
    chk("bp_drained_res", 32'(res_valid), 32'd0);
    chk("bp_drained_start", 32'(div_start), 32'd0);
    chk("bp_drained_ready", 32'(cmd_ready), 32'd1);

    // Timeout, then next queued job proceeds
    push_job(10'd200, 10'd9);
    push_job(10'd81, 10'd9);
    await_wait(lat, hi);
    chk("tmo_start_len", hi, 32'd2);
    cnt_a = 0;
    for (int unsigned i = 0; i < 62; i++) begin
      tick();
      if (div_sclr) cnt_a++;
    end
    chk("tmo_no_early_sclr", cnt_a, 32'd0);
    chk("tmo_no_early_res", 32'(res_valid), 32'd0);
    tick();
    chk("tmo_sclr_pulse", 32'(div_sclr), 32'd1);
    take_result("tmo", 10'd0, 2'b11);
    chk("tmo_sclr_end", 32'(div_sclr), 32'd0);
    await_wait(lat, hi);
    chk("tmo_next_a", 32'(div_a), 32'd81);
    pulse(1'b1, 1'b0, 1'b0, 10'd9);
    take_result("tmo_next", 10'd9, 2'b00);
    chk("tmo_no_stray", 32'(stray_err), 32'd0);

    // Completion pulse on the last WAIT cycle beats the timeout
    push_job(10'd49, 10'd7);
    await_wait(lat, hi);
    repeat (62) tick();
    pulse(1'b1, 1'b0, 1'b0, 10'd7);
    chk("edge_no_sclr", 32'(div_sclr), 32'd0);
    take_result("edge", 10'd7, 2'b00);

    // Collisions: dvz beats valid, ovf beats valid
    push_job(10'd30, 10'd0);
    await_wait(lat, hi);
    tick();
    pulse(1'b1, 1'b1, 1'b0, 10'd5);
    take_result("col_dvz", 10'd0, 2'b01);
    push_job(10'd900, 10'd1);
    await_wait(lat, hi);
    pulse(1'b1, 1'b0, 1'b1, 10'd5);
    take_result("col_ovf", 10'd0, 2'b10);

    // Stray pulse in IDLE
    tick();
    pulse(1'b1, 1'b0, 1'b0, 10'd3);
    chk("stray_set", 32'(stray_err), 32'd1);
    chk("stray_no_res", 32'(res_valid), 32'd0);
    repeat (5) tick();
    chk("stray_sticky", 32'(stray_err), 32'd1);
    chk("stray_still_no_res", 32'(res_valid), 32'd0);

    // Reset mid-WAIT with 3 jobs queued
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_a = ja[i];
      cmd_b = jb[i];
      tick();
    end
    cmd_valid = 1'b0;
    chk("mid_in_wait", 32'(div_start), 32'd0);
    chk("mid_a", 32'(div_a), 32'(ja[0]));
    sclr_n = 1'b0;
    #1;
    chk("mid_sclr_during", 32'(div_sclr), 32'd1);
    chk("mid_ready_during", 32'(cmd_ready), 32'd0);
    tick();
    chk("mid_rst_start", 32'(div_start), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_stray", 32'(stray_err), 32'd0);
    chk("mid_rst_a", 32'(div_a), 32'd0);
    chk("mid_rst_b", 32'(div_b), 32'd0);
    chk("mid_rst_q", 32'(res_q), 32'd0);
    chk("mid_rst_status", 32'(res_status), 32'd0);
    chk("mid_rst_sclr", 32'(div_sclr), 32'd1);
    sclr_n = 1'b1;
    tick();
    chk("mid_rel_sclr", 32'(div_sclr), 32'd0);
    chk("mid_rel_ready", 32'(cmd_ready), 32'd1);
    cnt_a = 0;
    cnt_b = 0;
    for (int unsigned i = 0; i < 30; i++) begin
      if (div_start) cnt_a++;
      if (res_valid) cnt_b++;
      tick();
    end
    chk("mid_no_start_after", cnt_a, 32'd0);
    chk("mid_no_result_after", cnt_b, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
